// File: rtl/lvds_word_align.sv
// lvds_word_align: trains each deserialized LVDS lane in turn by pulsing
// bitslip until the lane word repeats the training pattern MATCH_N times in
// a row. A lane that has been slipped DW times without locking is marked
// failed. The data path (dout) is a plain one-cycle register of din that is
// independent of the training FSM.
module lvds_word_align #(
    parameter int NCH         = 4,
    parameter int DW          = 8,
    parameter int SETTLE      = 3,
    parameter int MATCH_N     = 4,
    parameter int BIT_REVERSE = 0
) (
    input  logic              i_clk_div,
    input  logic              i_reset,
    input  logic [NCH*DW-1:0] i_din,
    input  logic [DW-1:0]     i_train_pattern,
    input  logic              i_start,
    output logic [NCH-1:0]    o_bitslip,
    output logic [NCH*DW-1:0] o_dout,
    output logic [NCH-1:0]    o_lane_locked,
    output logic [NCH-1:0]    o_fail,
    output logic [NCH*5-1:0]  o_slip_count,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW        = $clog2(DW + 1);
    localparam int MW        = (MATCH_N > 1) ? $clog2(MATCH_N) : 1;
    localparam int WW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int SETTLE_M1 = (SETTLE > 0) ? SETTLE - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SLIP,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [CHW-1:0]      r_ch;
    logic [MW-1:0]       r_match;
    logic [SW-1:0]       r_slips;
    logic [WW-1:0]       r_wcnt;
    logic [NCH-1:0]      r_bitslip;
    logic [NCH-1:0]      r_locked;
    logic [NCH-1:0]      r_fail;
    logic [NCH*5-1:0]    r_slip_count;
    logic                r_done;
    logic [NCH*DW-1:0]   r_dout;
    logic [NCH*DW-1:0]   w_din_ord;
    logic [DW-1:0]       w_lane;
    logic                w_hit;

    // Optional per-lane bit reversal ahead of the output register
    genvar k, b;
    generate
        for (k = 0; k < NCH; k++) begin : g_lane
            for (b = 0; b < DW; b++) begin : g_bit
                if (BIT_REVERSE != 0) begin : g_rev
                    assign w_din_ord[k*DW+b] = i_din[k*DW+DW-1-b];
                end else begin : g_fwd
                    assign w_din_ord[k*DW+b] = i_din[k*DW+b];
                end
            end
        end
    endgenerate

    // Training compares the raw lane word, never the reversed one
    assign w_lane = i_din[r_ch*DW +: DW];
    assign w_hit  = (w_lane == i_train_pattern);

    // Output data register: one-cycle copy of din in every FSM state
    always_ff @(posedge i_clk_div) begin
        if (i_reset) r_dout <= '0;
        else         r_dout <= w_din_ord;
    end

    // Training FSM; bitslip and done are one-cycle registered pulses
    always_ff @(posedge i_clk_div) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_ch         <= '0;
            r_match      <= '0;
            r_slips      <= '0;
            r_wcnt       <= '0;
            r_bitslip    <= '0;
            r_locked     <= '0;
            r_fail       <= '0;
            r_slip_count <= '0;
            r_done       <= 1'b0;
        end else begin
            r_bitslip <= '0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_locked     <= '0;
                        r_fail       <= '0;
                        r_slip_count <= '0;
                        r_ch         <= '0;
                        r_match      <= '0;
                        r_slips      <= '0;
                        r_state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_hit) begin
                        if (r_match == MW'(MATCH_N - 1)) begin
                            r_locked[r_ch] <= 1'b1;
                            r_state        <= S_NEXT;
                        end else begin
                            r_match <= r_match + 1'b1;
                        end
                    end else begin
                        // any miss restarts the consecutive-match run
                        r_match <= '0;
                        if (r_slips == SW'(DW)) begin
                            r_fail[r_ch] <= 1'b1;
                            r_state      <= S_NEXT;
                        end else begin
                            // raise the pulse so it is visible during SLIP
                            r_bitslip[r_ch] <= 1'b1;
                            r_state         <= S_SLIP;
                        end
                    end
                end
                S_SLIP: begin
                    r_slips                  <= r_slips + 1'b1;
                    r_slip_count[r_ch*5 +: 5] <= 5'(r_slips + 1'b1);
                    r_wcnt                   <= '0;
                    r_state                  <= (SETTLE == 0) ? S_CHECK : S_WAIT;
                end
                S_WAIT: begin
                    r_match <= '0;
                    if (r_wcnt == WW'(SETTLE_M1)) r_state <= S_CHECK;
                    else                          r_wcnt  <= r_wcnt + 1'b1;
                end
                S_NEXT: begin
                    if (r_ch == CHW'(NCH - 1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_slips <= '0;
                        r_match <= '0;
                        r_state <= S_CHECK;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_bitslip     = r_bitslip;
    assign o_dout        = r_dout;
    assign o_lane_locked = r_locked;
    assign o_fail        = r_fail;
    assign o_slip_count  = r_slip_count;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;

endmodule

// File: tb/tb_lvds_word_align.sv
// Bench for lvds_word_align: a behavioural deserializer model rotates each
// lane on bitslip; expected lock/fail/slip counts and run length come from a
// per-lane arithmetic model of the training rules.
module tb_lvds_word_align;

    localparam int NCH = 4, DW = 8, SETTLE = 3, MATCH_N = 4;

    logic              clk = 1'b0;
    logic              reset, start, load;
    logic [DW-1:0]     pat;
    logic [NCH*DW-1:0] din, din_q;
    logic [NCH-1:0]    bitslip, locked, fail;
    logic [NCH*DW-1:0] dout;
    logic [NCH*5-1:0]  slip_count;
    logic              busy, done;
    logic [NCH-1:0]    bitslip_r, locked_r, fail_r;
    logic [NCH*DW-1:0] dout_r;
    logic [NCH*5-1:0]  slip_count_r;
    logic              busy_r, done_r;

    // lane source modes: 0 rotated pattern (slips rotate), 1 never matches,
    // 2 pattern with one glitch word, 3 fixed word
    int          mode[NCH];
    int          rot_init[NCH];
    logic [DW-1:0] fixw[NCH];
    int          gcyc = -100;
    int          rot[NCH];
    logic [DW-1:0] nmw[NCH];
    int          cyc = 0;
    int          pcnt[NCH];
    int          last[NCH];
    int          oh_err = 0, sp_err = 0;

    int          ntests = 0, nfail = 0;
    int          exp_lat;
    logic [NCH-1:0] exp_lock, exp_fail;
    int          exp_sl[NCH];

    always #5 clk = ~clk;

    lvds_word_align #(.NCH(NCH), .DW(DW), .SETTLE(SETTLE), .MATCH_N(MATCH_N), .BIT_REVERSE(0)) u_dut (
        .i_clk_div(clk), .i_reset(reset), .i_din(din), .i_train_pattern(pat), .i_start(start),
        .o_bitslip(bitslip), .o_dout(dout), .o_lane_locked(locked), .o_fail(fail),
        .o_slip_count(slip_count), .o_busy(busy), .o_done(done));

    lvds_word_align #(.NCH(NCH), .DW(DW), .SETTLE(SETTLE), .MATCH_N(MATCH_N), .BIT_REVERSE(1)) u_rev (
        .i_clk_div(clk), .i_reset(reset), .i_din(din), .i_train_pattern(pat), .i_start(start),
        .o_bitslip(bitslip_r), .o_dout(dout_r), .o_lane_locked(locked_r), .o_fail(fail_r),
        .o_slip_count(slip_count_r), .o_busy(busy_r), .o_done(done_r));

    function automatic logic [DW-1:0] rotr(input logic [DW-1:0] w, input int n);
        logic [DW-1:0] r;
        r = w;
        for (int i = 0; i < n % DW; i++) r = {r[0], r[DW-1:1]};
        return r;
    endfunction

    function automatic logic [NCH*DW-1:0] rev_all(input logic [NCH*DW-1:0] v);
        logic [NCH*DW-1:0] o;
        for (int k = 0; k < NCH; k++)
            for (int i = 0; i < DW; i++) o[k*DW+i] = v[k*DW+DW-1-i];
        return o;
    endfunction

    // deserializer output as seen by the DUT
    always_comb begin
        din = '0;
        for (int k = 0; k < NCH; k++) begin
            case (mode[k])
                0:       din[k*DW +: DW] = rotr(pat, rot[k]);
                1:       din[k*DW +: DW] = (nmw[k] == pat) ? ~pat : nmw[k];
                2:       din[k*DW +: DW] = (cyc == gcyc) ? ~pat : pat;
                default: din[k*DW +: DW] = fixw[k];
            endcase
        end
    end

    // deserializer state, pulse counting and pulse-spacing monitor
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        din_q <= din;
        for (int k = 0; k < NCH; k++) nmw[k] <= DW'($urandom);
        if (load) begin
            for (int k = 0; k < NCH; k++) begin
                rot[k]  <= rot_init[k];
                pcnt[k] <= 0;
                last[k] <= -1;
            end
            oh_err <= 0;
            sp_err <= 0;
        end else begin
            if ($countones(bitslip) > 1) oh_err <= oh_err + 1;
            for (int k = 0; k < NCH; k++) begin
                if (bitslip[k]) begin
                    pcnt[k] <= pcnt[k] + 1;
                    if (last[k] >= 0 && cyc - last[k] != SETTLE + 2) sp_err <= sp_err + 1;
                    last[k] <= cyc;
                    if (mode[k] == 0) rot[k] <= (rot[k] + DW - 1) % DW;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        ntests++;
        assert (got === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // per-lane outcome and total run length from the training rules
    task automatic model_run();
        int tot;
        bit found;
        int j;
        tot = 2;  // start-sampling cycle plus the DONE cycle
        for (int k = 0; k < NCH; k++) begin
            exp_lock[k] = 1'b0;
            exp_fail[k] = 1'b0;
            if (mode[k] == 0) begin
                found = 0;
                j = 0;
                for (int s = 0; s <= DW && !found; s++)
                    if (rotr(pat, (rot_init[k] + DW - s) % DW) == pat) begin
                        found = 1;
                        j = s;
                    end
                exp_lock[k] = 1'b1;
                exp_sl[k]   = j;
                tot += j * (SETTLE + 2) + MATCH_N + 1;
            end else if (mode[k] == 2) begin
                exp_lock[k] = 1'b1;
                exp_sl[k]   = 1;
                tot += (MATCH_N - 1) + 2 + SETTLE + MATCH_N + 1;
            end else begin
                exp_fail[k] = 1'b1;
                exp_sl[k]   = DW;
                tot += DW * (SETTLE + 2) + 2;
            end
        end
        exp_lat = tot;
    endtask

    task automatic do_run(input bit restrike, output int lat);
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
        start = 1'b1;
        gcyc  = cyc + MATCH_N;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        chk("busy_after_start", busy, 1);
        while (done !== 1'b1 && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
            start = (restrike && lat == 5);
        end
        start = 1'b0;
    endtask

    task automatic run_check(input string tag, input bit restrike);
        int lat;
        do_run(restrike, lat);
        model_run();
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_locked"}, locked, exp_lock);
        chk({tag, "_fail"}, fail, exp_fail);
        chk({tag, "_lock_and_fail"}, locked & fail, 0);
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("%s_slip_count%0d", tag, k), slip_count[k*5 +: 5], exp_sl[k]);
            chk($sformatf("%s_pulses%0d", tag, k), pcnt[k], exp_sl[k]);
        end
        chk({tag, "_onehot"}, oh_err, 0);
        chk({tag, "_spacing"}, sp_err, 0);
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        int n, p;
        reset = 1'b1; start = 1'b1; load = 1'b1; pat = 8'hA5;
        for (int k = 0; k < NCH; k++) begin
            mode[k] = 0; rot_init[k] = 0; fixw[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        // reset wins over a simultaneous start
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bitslip", bitslip, 0);
        chk("rst_locked", locked, 0);
        chk("rst_fail", fail, 0);
        chk("rst_slip_count", slip_count, 0);
        chk("rst_dout", dout, 0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0; load = 1'b0;

        // data path: one-cycle delay, forward and reversed
        for (int k = 0; k < NCH; k++) mode[k] = 1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("dout_delay", dout, din_q);
            chk("dout_rev_delay", dout_r, rev_all(din_q));
        end
        @(negedge clk);
        for (int k = 0; k < NCH; k++) begin mode[k] = 3; fixw[k] = 8'h3C; end
        fixw[0] = 8'h01;
        @(posedge clk); #1;
        chk("rev_01", dout_r[DW-1:0], 8'h80);
        chk("fwd_01", dout[DW-1:0], 8'h01);
        chk("idle_no_pulse", bitslip, 0);

        // all lanes already aligned; a second start mid-run is ignored
        for (int k = 0; k < NCH; k++) begin mode[k] = 0; rot_init[k] = 0; end
        run_check("aligned", 1'b1);
        chk("aligned_latency_formula", exp_lat, NCH*MATCH_N + NCH + 2);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_locked", locked, 4'b1111);
        chk("hold_busy", busy, 0);

        // lane 2 three bits off
        rot_init[2] = 3;
        run_check("lane2_rot3", 1'b0);
        chk("lane2_slip_count3", slip_count[2*5 +: 5], 3);
        rot_init[2] = 0;

        // lane 1 never matches
        mode[1] = 1;
        run_check("lane1_fail", 1'b0);
        chk("lane1_fail_bit", fail[1], 1);
        mode[1] = 0;

        // lane 0 glitch after MATCH_N-1 good words
        mode[0] = 2;
        run_check("lane0_glitch", 1'b0);
        mode[0] = 0;

        // randomized patterns, offsets and dead lanes
        for (int r = 0; r < 5; r++) begin
            pat = DW'($urandom);
            for (int k = 0; k < NCH; k++) begin
                mode[k]     = ($urandom_range(0, 3) == 0) ? 1 : 0;
                rot_init[k] = $urandom_range(0, DW - 1);
            end
            run_check($sformatf("rand%0d", r), 1'b0);
        end

        // reset during WAIT on lane 2
        pat = 8'hA5;
        for (int k = 0; k < NCH; k++) begin mode[k] = 0; rot_init[k] = 0; end
        rot_init[2] = 3;
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (bitslip[2] !== 1'b1 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_slip2_seen", bitslip[2], 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_bitslip", bitslip, 0);
        chk("abort_locked", locked, 0);
        chk("abort_fail", fail, 0);
        chk("abort_slip_count", slip_count, 0);
        chk("abort_dout", dout, 0);
        p = pcnt[2];
        @(negedge clk) reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_more_pulses", pcnt[2], p);
        chk("abort_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/lvds_word_align.md
LVDS_WORD_ALIGN -- requirements
Module: lvds_word_align

Interface
REQ-001 SHALL provide parameter NCH, default 4, number of deserialized data lanes.
REQ-002 SHALL provide parameter DW, default 8, word width per lane (legal 4..16).
REQ-003 SHALL provide parameter SETTLE, default 3, clk_div cycles waited after each bitslip pulse before re-checking.
REQ-004 SHALL provide parameter MATCH_N, default 4, consecutive matching words required to declare lock (>=1).
REQ-005 SHALL provide parameter BIT_REVERSE, default 0; 1 reverses bit order within each lane word on dout.
REQ-006 clk_div  in  1  sole clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 din  in  NCH*DW  deserialized words; lane k at bits [k*DW +: DW].
REQ-009 train_pattern  in  DW  expected training word; held stable while busy.
REQ-010 start  in  1  single-cycle request to begin training all lanes.
REQ-011 bitslip  out  NCH  one-cycle bitslip pulse per lane, to the deserializer.
REQ-012 dout  out  NCH*DW  registered (optionally bit-reversed) copy of din.
REQ-013 lane_locked  out  NCH  lane aligned in the last training run.
REQ-014 fail  out  NCH  lane exhausted DW slips without lock in the last run.
REQ-015 slip_count  out  NCH*5  slips applied to each lane in the last run.
REQ-016 busy  out  1  high whenever the FSM is not IDLE.
REQ-017 done  out  1  one-cycle pulse at end of a training run.

Function
REQ-018 dout SHALL equal din delayed exactly one clk_div cycle, in every state; with BIT_REVERSE=1, dout lane bit i = din lane bit DW-1-i.
REQ-019 The FSM SHALL have states IDLE, CHECK, SLIP, WAIT, NEXT, DONE, and SHALL train lanes sequentially via index ch = 0..NCH-1.
REQ-020 IDLE: on start=1, clear lane_locked, fail, slip_count for all lanes; set ch=0, match_cnt=0, slips=0; go CHECK next cycle.
REQ-021 start SHALL be ignored when busy=1.
REQ-022 CHECK: compare din lane ch (raw, not reversed) with train_pattern once per cycle.
REQ-023 CHECK match: match_cnt++; when this is the MATCH_N-th consecutive match, set lane_locked[ch]=1 and go NEXT.
REQ-024 CHECK mismatch: match_cnt=0; if slips==DW set fail[ch]=1 and go NEXT, else go SLIP.
REQ-025 SLIP: assert bitslip[ch]=1 for exactly this one cycle, slips++, slip_count[ch]=slips+1; go WAIT.
REQ-026 WAIT: hold exactly SETTLE cycles (bitslip all zero, din ignored), then go CHECK with match_cnt=0.
REQ-027 NEXT: if ch==NCH-1 go DONE; else ch++, slips=0, match_cnt=0, go CHECK.
REQ-028 DONE: assert done=1 for one cycle, go IDLE; lane_locked, fail, slip_count SHALL hold until next start or reset.
REQ-029 At most one bitslip bit SHALL be high in any cycle; bitslip bits of lanes other than ch SHALL be 0.
REQ-030 lane_locked[k] and fail[k] SHALL never both be 1.
REQ-031 Lock check is consecutive: one mismatch after partial matches SHALL restart counting and cause a slip (subject to REQ-024).

Reset
REQ-032 reset=1 SHALL, on the next clk_div edge, force state IDLE, bitslip=0, done=0, busy=0, lane_locked=0, fail=0, slip_count=0, dout=0, ch=0, internal counters 0.
REQ-033 reset asserted mid-run (any state) SHALL abort training with no further bitslip pulses; reset SHALL take priority over simultaneous start.

Verification
REQ-034 NCH=4, DW=8, all lanes already equal to pattern 0xA5, start -> no bitslip pulses, lane_locked=4'b1111, slip_count all 0, done pulses after NCH*MATCH_N + NCH + 2 cycles.
REQ-035 Lane 2 model rotates by 3 bits, each bitslip rotates one bit -> exactly 3 pulses on bitslip[2], each separated by SETTLE+2 cycles, slip_count[2]=3, lane_locked[2]=1.
REQ-036 Lane 1 never matches -> 8 pulses on bitslip[1], fail[1]=1, lane_locked[1]=0, remaining lanes still trained, done asserted.
REQ-037 Lane 0 matches 3 cycles then mismatches once (MATCH_N=4) -> one slip issued, count restarts, lock only after 4 fresh consecutive matches.
REQ-038 reset asserted during WAIT on lane 2 -> next cycle all outputs 0, busy=0, no pulses; start while busy ignored; BIT_REVERSE=1 din 0x01 -> dout 0x80 one cycle later.
